// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide execute unit.
//
// Multiply uses a shift-add over XLEN cycles. Divide uses a restoring algorithm over XLEN cycles.
// Both run on operand magnitudes, and the signs are fixed up on the final iteration.
// Divide-by-zero and signed overflow skip the iteration and finish one edge after accept.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   flush               kills any operation; returns to IDLE at the next edge
//   in_valid/in_ready   op handshake (funct3, op_a, op_b sampled at accept)
//   out_valid/out_ready result handshake; result holds under backpressure
//   result              rd value
//   busy                unit is not IDLE
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  // Multiplier (shifted right each step) or divisor (held).
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  // Multiplicand, shifted left each step of a multiply.
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  // Product accumulator, or {remainder, dividend/quotient} for a divide.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------------
  // Accept-side decode
  // ---------------------------------------------------------------------------
  logic            signed_a, signed_b, is_div;
  logic            in_sign_a, in_sign_b;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div    = funct3[2];
    signed_a  = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_sign_a = signed_a & op_a[XLEN-1];
    in_sign_b = signed_b & op_b[XLEN-1];
    in_mag_a  = in_sign_a ? -op_a : op_a;
    in_mag_b  = in_sign_b ? -op_b : op_b;
    div_zero  = is_div && (op_b == '0);
    div_ovf   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else if (div_ovf) begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of multiply or divide
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] acc_mul, acc_div, acc_iter;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   trial;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new;

  always_comb begin
    acc_mul   = acc_q + (mag_b_q[0] ? mcand_q : {(2*XLEN){1'b0}});
    // Remainder shifted left with the next dividend bit brought in.
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    trial     = {1'b0, rem_shift} - {2'b00, mag_b_q};
    q_bit     = ~trial[XLEN+1];
    rem_new   = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    acc_div   = {rem_new, acc_q[XLEN-2:0], q_bit};
    acc_iter  = funct3_q[2] ? acc_div : acc_mul;
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select, applied to the final iteration's value
  // ---------------------------------------------------------------------------
  logic              neg_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    // Unsigned forms record both signs as 0, so they never negate.
    neg_res  = sign_a_q ^ sign_b_q;
    prod_fix = neg_res ? -acc_iter : acc_iter;
    quo_fix  = neg_res ? -acc_iter[XLEN-1:0] : acc_iter[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_iter[2*XLEN-1:XLEN] : acc_iter[2*XLEN-1:XLEN];
    case (funct3_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_b_d  = mag_b_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          funct3_d = funct3;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          mag_b_d  = in_mag_b;
          mcand_d  = {{XLEN{1'b0}}, in_mag_a};
          acc_d    = is_div ? {{XLEN{1'b0}}, in_mag_a} : {(2*XLEN){1'b0}};
          cnt_d    = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        acc_d = acc_iter;
        cnt_d = cnt_q + CW'(1);
        if (!funct3_q[2]) begin
          mcand_d = mcand_q << 1;
          mag_b_d = mag_b_q >> 1;
        end
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_b_q  <= mag_b_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  // Second instance at XLEN=64.
  logic        in_valid64, in_ready64, out_valid64, busy64;
  logic [2:0]  funct3_64;
  logic [63:0] op_a64, op_b64, result64;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    int          tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk       (clk),
    .reset     (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  muldiv_unit #(.XLEN(64)) u_dut64 (
    .clk       (clk),
    .reset     (rst),
    .flush     (1'b0),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .funct3    (funct3_64),
    .op_a      (op_a64),
    .op_b      (op_b64),
    .out_valid (out_valid64),
    .out_ready (1'b1),
    .result    (result64),
    .busy      (busy64)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: latency counts rising edges from the accept edge inclusive,
  // so a special case reports 1 and a normal 32-bit op reports 33.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("result_op%0d", e.tag), 64'(result), 64'(e.res));
        check($sformatf("latency_op%0d", e.tag), 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
    prev_v <= out_valid;
  end

  int tag_n = 0;

  // Waits for IDLE, presents the op for one edge, then scrambles the inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    funct3   = f;
    op_a     = a;
    op_b     = b;
    tag_n++;
    if (push) exp_q.push_back('{res: exp, lat: lat, acc: cyc + 1, tag: tag_n});
    @(negedge clk);
    in_valid = 1'b0;
    funct3   = ~f;
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int acc64;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0;
    in_valid64 = 1'b0; funct3_64 = '0; op_a64 = '0; op_b64 = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst = 1'b0;

    // Multiply forms.
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1);
    // Divide forms.
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1);
    issue(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1);
    issue(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1);
    // Special cases.
    issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
    issue(3'b111, 32'd5, 32'd0, 32'd5, 1, 1);
    issue(3'b110, 32'd5, 32'd0, 32'd5, 1, 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
    wait_drain();

    // Backpressure, then a back-to-back op held across the release edge.
    out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd14);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    tag_n++;
    exp_q.push_back('{res: 32'd12, lat: 33, acc: cyc + 2, tag: tag_n});
    @(negedge clk);
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_drain();

    // Flush mid-run, then flush with in_valid in IDLE.
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_no_accept", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 32'd12, 33, 1);
    wait_drain();

    // Asynchronous reset between edges mid-run.
    issue(3'b000, 32'd3, 32'd4, 32'd0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);

    // XLEN=64 MULHU.
    @(negedge clk);
    in_valid64 = 1'b1; funct3_64 = 3'b011; op_a64 = '1; op_b64 = '1;
    acc64 = cyc + 1;
    @(negedge clk);
    in_valid64 = 1'b0; op_a64 = '0; op_b64 = '0;
    n = 0;
    while (!out_valid64 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("x64_out_valid", 64'(out_valid64), 64'd1);
    check("x64_result", result64, 64'hFFFF_FFFF_FFFF_FFFE);
    check("x64_latency", 64'(cyc - acc64 + 1), 64'd65);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised RV32M/RV64M multiply/divide execute unit in the EX stage, alongside the single-cycle ALU.
- Decodes the M-extension funct3 when the controller flags an M-type R instruction (Funct7 = 0000001).
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles, bypasses RISC-V special cases, and returns the result through a valid/ready handshake.
- The pipeline stalls on in_ready low or while waiting for out_valid.

Parameters:
- XLEN, 32, operand/result width; legal values 32 and 64. The iteration counter width is $clog2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- flush  input  1  pipeline kill; aborts any operation
- in_valid  input  1  EX holds an M-type op
- in_ready  output  1  unit can accept an op
- funct3  input  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value
- op_b  input  XLEN  rs2 value
- out_valid  output  1  result available
- out_ready  input  1  writeback consumes the result
- result  output  XLEN  rd value
- busy  output  1  state != IDLE

Behaviour:
Reset:
- Asynchronous reset forces state IDLE, counter 0, and internal registers 0.
- Outputs during reset: in_ready=1, out_valid=0, busy=0, result=0.

States:
- IDLE: in_ready=1. An op is accepted on a clock edge where in_valid=1, in_ready=1 and flush=0.
  - On accept, latch funct3, record the operand signs, and load the magnitudes |op_a| and |op_b|. Signed ops (MULH, DIV, REM; MULHSU for op_a only) take magnitudes; all other ops use the raw operands.
  - Divide by zero (op_b=0, funct3[2]=1) goes to DONE with result = all-ones for DIV/DIVU, op_a for REM/REMU.
  - Signed overflow (DIV/REM, op_a = 1 followed by XLEN-1 zeros, op_b = all-ones) goes to DONE with result = op_a for DIV, 0 for REM.
  - All other ops go to RUN with counter=0.
- RUN: one iteration per cycle, XLEN cycles total; in_ready=0.
  - Multiply: 2*XLEN-bit accumulator, add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: restoring divide, shift the remainder left by one, trial-subtract the divisor, set the quotient bit when the difference is non-negative.
  - When counter reaches XLEN-1, the next state is DONE and the sign fix-up is applied that edge:
    - Product is negated if the operand signs differ, for signed forms only.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: out_valid=1 and result stable.
  - On an edge with out_ready=1, go to IDLE; out_valid falls the next cycle.
  - out_valid and result hold while out_ready=0 (backpressure).
  - No new op is accepted in DONE (in_ready=0).

Latency:
- Normal op: out_valid rises exactly XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Special case: out_valid rises 1 cycle after the accept edge.

Flush:
- flush=1 in any state forces IDLE at the next edge; out_valid=0 from that edge and the result is discarded.
- flush has priority over accept, iteration and out_ready.
- A flush in IDLE with in_valid=1 accepts nothing.

Other rules:
- Back-to-back: the DONE→IDLE edge cannot also accept; the next accept is possible one cycle later.
- Arithmetic is modulo 2^XLEN; no exceptions are raised.
- funct3 and operands are sampled only at accept; changes on them during RUN are ignored.
- Reset asserted mid-RUN clears immediately without waiting for a clock edge.

Test Plan:
- MULHU, XLEN=32, a=0xFFFFFFFF, b=0xFFFFFFFF → result 0xFFFFFFFE, out_valid 33 cycles after accept. MUL with the same operands → 0x00000001.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0x00000000. MULHSU with the same operands → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14.
- Special cases, each giving out_valid 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- DIVU 100/7 with out_ready held low 5 cycles after out_valid → result 14 held stable. Release: out_valid drops next cycle, in_ready returns, and the next op is accepted one cycle later.
- Flush at cycle 10 of a RUN → IDLE next edge, out_valid never asserts. A following MUL 3*4 → 12.
- Async reset pulsed mid-RUN between clock edges → in_ready=1, out_valid=0, busy=0 immediately. Repeat the MUL test at XLEN=64: 0xFFFFFFFFFFFFFFFF squared via MULHU → 0xFFFFFFFFFFFFFFFE, latency 65.
